// File: rtl/lcd_memdisp_sink.sv
// Passive decoder for the memory-LCD serial link (lcd_sclk/lcd_si/lcd_scs).
// Oversamples the link on clk12 and emits mode, line address and WORD-bit pixel words with markers.
module lcd_memdisp_sink #(
    parameter int LINE_BITS  = 336,
    parameter int ADDR_BITS  = 10,
    parameter int MODE_BITS  = 6,
    parameter int TRAIL_BITS = 16,
    parameter int WORD       = 16
) (
    input  logic                 clk12,
    input  logic                 reset,
    input  logic                 lcd_sclk,
    input  logic                 lcd_si,
    input  logic                 lcd_scs,
    output logic                 mode_valid,
    output logic [MODE_BITS-1:0] mode,
    output logic                 clear_all,
    output logic                 line_start,
    output logic [ADDR_BITS-1:0] line_addr,
    output logic                 pix_valid,
    output logic [WORD-1:0]      pix_data,
    output logic                 line_done,
    output logic                 frame_done,
    output logic                 err_abort
);

    localparam int MAX_AM    = (MODE_BITS > ADDR_BITS) ? MODE_BITS : ADDR_BITS;
    localparam int MAX_DT    = (LINE_BITS > TRAIL_BITS) ? LINE_BITS : TRAIL_BITS;
    localparam int MAX_FIELD = (MAX_AM > MAX_DT) ? MAX_AM : MAX_DT;
    localparam int CNT_W     = $clog2(MAX_FIELD + 1);
    localparam int WCNT_W    = $clog2(WORD + 1);
    localparam int SH_W      = (MAX_AM > WORD) ? MAX_AM : WORD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MODE,
        ST_ADDR,
        ST_DATA,
        ST_TRAIL,
        ST_CLR
    } state_t;

    state_t            state;
    logic              armed;
    logic [CNT_W-1:0]  cnt;
    logic [WCNT_W-1:0] wcnt;
    logic [SH_W-2:0]   sh;
    logic [SH_W-1:0]   sh_next;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic si_s1, si_s2;
    logic scs_s1, scs_s2, scs_s3;
    logic sclk_rise, scs_rise, scs_fall, bit_take;

    // scs synchronisers reset high so a link that is mid-frame at reset never arms the decoder.
    always_ff @(posedge clk12) begin
        if (reset) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            si_s1   <= 1'b0;
            si_s2   <= 1'b0;
            scs_s1  <= 1'b1;
            scs_s2  <= 1'b1;
            scs_s3  <= 1'b1;
        end else begin
            sclk_s1 <= lcd_sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            si_s1   <= lcd_si;
            si_s2   <= si_s1;
            scs_s1  <= lcd_scs;
            scs_s2  <= scs_s1;
            scs_s3  <= scs_s2;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign scs_rise  = scs_s2 & ~scs_s3;
    assign scs_fall  = ~scs_s2 & scs_s3;
    assign bit_take  = sclk_rise & scs_s2 & ~scs_rise;
    assign sh_next   = {sh, si_s2};

    always_ff @(posedge clk12) begin
        if (reset) begin
            sh <= '0;
        end else if (bit_take) begin
            sh <= sh_next[SH_W-2:0];
        end
    end

    always_ff @(posedge clk12) begin
        if (reset) begin
            state      <= ST_IDLE;
            armed      <= 1'b0;
            cnt        <= '0;
            wcnt       <= '0;
            mode_valid <= 1'b0;
            mode       <= '0;
            clear_all  <= 1'b0;
            line_start <= 1'b0;
            line_addr  <= '0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            err_abort  <= 1'b0;
        end else begin
            mode_valid <= 1'b0;
            clear_all  <= 1'b0;
            line_start <= 1'b0;
            pix_valid  <= 1'b0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            err_abort  <= 1'b0;
            if (!scs_s2) begin
                armed <= 1'b1;
            end
            // A chip-select drop wins over any bit arriving in the same cycle.
            if (scs_fall && state != ST_IDLE) begin
                if (state == ST_CLR || (state == ST_ADDR && cnt == '0)) begin
                    frame_done <= 1'b1;
                end else begin
                    err_abort <= 1'b1;
                end
                state <= ST_IDLE;
                cnt   <= '0;
                wcnt  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (scs_rise && armed) begin
                            state <= ST_MODE;
                            cnt   <= '0;
                            wcnt  <= '0;
                        end
                    end
                    ST_MODE: begin
                        if (bit_take) begin
                            if (cnt == CNT_W'(MODE_BITS - 1)) begin
                                mode_valid <= 1'b1;
                                mode       <= sh_next[MODE_BITS-1:0];
                                cnt        <= '0;
                                if (sh_next[2]) begin
                                    clear_all <= 1'b1;
                                    state     <= ST_CLR;
                                end else begin
                                    state <= ST_ADDR;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (bit_take) begin
                            if (cnt == CNT_W'(ADDR_BITS - 1)) begin
                                line_start <= 1'b1;
                                line_addr  <= sh_next[ADDR_BITS-1:0];
                                cnt        <= '0;
                                wcnt       <= '0;
                                state      <= ST_DATA;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (bit_take) begin
                            if (wcnt == WCNT_W'(WORD - 1)) begin
                                pix_valid <= 1'b1;
                                pix_data  <= sh_next[WORD-1:0];
                                wcnt      <= '0;
                            end else begin
                                wcnt <= wcnt + 1'b1;
                            end
                            if (cnt == CNT_W'(LINE_BITS - 1)) begin
                                state <= ST_TRAIL;
                                cnt   <= '0;
                                wcnt  <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    ST_TRAIL: begin
                        if (bit_take) begin
                            if (cnt == CNT_W'(TRAIL_BITS - 1)) begin
                                line_done <= 1'b1;
                                cnt       <= '0;
                                state     <= ST_ADDR;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    ST_CLR: begin
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        wcnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_memdisp_sink.sv
// Bench for lcd_memdisp_sink: drives whole link frames and compares decoded events
// against a frame-level parse of the transmitted bit list.
module tb_lcd_memdisp_sink;

    localparam int LB  = 336;
    localparam int AB  = 10;
    localparam int MB  = 6;
    localparam int TRB = 16;
    localparam int W   = 16;

    logic          clk12 = 1'b0;
    logic          reset;
    logic          lcd_sclk, lcd_si, lcd_scs;
    logic          mode_valid, clear_all, line_start, pix_valid;
    logic          line_done, frame_done, err_abort;
    logic [MB-1:0] mode;
    logic [AB-1:0] line_addr;
    logic [W-1:0]  pix_data;

    int n_assert = 0;
    int n_fail   = 0;

    bit          frame_q[$];
    logic [31:0] exp_modes[$], exp_clr[$], exp_addrs[$], exp_words[$];
    logic [31:0] got_modes[$], got_clr[$], got_addrs[$], got_words[$];
    int exp_ldone, exp_fdone, exp_err, exp_nclear;
    int n_ldone, n_fdone, n_err, n_clear;

    lcd_memdisp_sink #(
        .LINE_BITS (LB),
        .ADDR_BITS (AB),
        .MODE_BITS (MB),
        .TRAIL_BITS(TRB),
        .WORD      (W)
    ) dut (
        .clk12     (clk12),
        .reset     (reset),
        .lcd_sclk  (lcd_sclk),
        .lcd_si    (lcd_si),
        .lcd_scs   (lcd_scs),
        .mode_valid(mode_valid),
        .mode      (mode),
        .clear_all (clear_all),
        .line_start(line_start),
        .line_addr (line_addr),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .line_done (line_done),
        .frame_done(frame_done),
        .err_abort (err_abort)
    );

    always #5 clk12 = ~clk12;

    // Record every output event on the falling edge, clear of the registered updates.
    always @(negedge clk12) begin
        if (mode_valid) begin
            got_modes.push_back(32'(mode));
            got_clr.push_back(32'(clear_all));
        end
        if (clear_all)  n_clear++;
        if (line_start) got_addrs.push_back(32'(line_addr));
        if (pix_valid)  got_words.push_back(32'(pix_data));
        if (line_done)  n_ldone++;
        if (frame_done) n_fdone++;
        if (err_abort)  n_err++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk12);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s[%0d]: observed 0x%0h, expected 0x%0h", name, idx, got, exp);
        end
    endtask

    task automatic push_bits(input logic [31:0] v, input int len);
        for (int i = len - 1; i >= 0; i--) frame_q.push_back(v[i]);
    endtask

    function automatic logic [31:0] take(input int start, input int len);
        logic [31:0] v = '0;
        for (int i = 0; i < len; i++) v = {v[30:0], frame_q[start + i]};
        return v;
    endfunction

    // Frame-level reference: walk the transmitted bit list field by field.
    task automatic model_frame(input bit dut_armed);
        int n, pos;
        logic [31:0] m;
        exp_modes.delete(); exp_clr.delete(); exp_addrs.delete(); exp_words.delete();
        exp_ldone = 0; exp_fdone = 0; exp_err = 0; exp_nclear = 0;
        if (!dut_armed) return;
        n = frame_q.size();
        if (n < MB) begin exp_err++; return; end
        m = take(0, MB);
        exp_modes.push_back(m);
        exp_clr.push_back({31'b0, m[2]});
        if (m[2]) begin exp_nclear++; exp_fdone++; return; end
        pos = MB;
        while (1) begin
            if (n == pos) begin exp_fdone++; return; end
            if (n - pos < AB) begin exp_err++; return; end
            exp_addrs.push_back(take(pos, AB));
            pos += AB;
            for (int w = 0; w < LB / W; w++) begin
                if (n - pos < W) begin exp_err++; return; end
                exp_words.push_back(take(pos, W));
                pos += W;
            end
            if (n - pos < TRB) begin exp_err++; return; end
            pos += TRB;
            exp_ldone++;
        end
    endtask

    task automatic send_bit(input bit b, input int period);
        lcd_si   = b;
        lcd_sclk = 1'b0;
        wait_clk(period / 2);
        lcd_sclk = 1'b1;
        wait_clk(period - period / 2);
    endtask

    task automatic apply_stimulus(input int period, input bit dut_armed);
        model_frame(dut_armed);
        got_modes.delete(); got_clr.delete(); got_addrs.delete(); got_words.delete();
        n_ldone = 0; n_fdone = 0; n_err = 0; n_clear = 0;
        lcd_sclk = 1'b0;
        lcd_scs  = 1'b1;
        wait_clk(4);
        foreach (frame_q[i]) send_bit(frame_q[i], period);
        lcd_sclk = 1'b0;
        wait_clk(3);
        lcd_scs = 1'b0;
        wait_clk(8);
    endtask

    task automatic check_output(input string tag);
        chk({tag, ".mode_count"}, 0, got_modes.size(), exp_modes.size());
        for (int i = 0; i < exp_modes.size() && i < got_modes.size(); i++) begin
            chk({tag, ".mode"}, i, got_modes[i], exp_modes[i]);
            chk({tag, ".clear_with_mode"}, i, got_clr[i], exp_clr[i]);
        end
        chk({tag, ".clear_count"}, 0, n_clear, exp_nclear);
        chk({tag, ".line_start_count"}, 0, got_addrs.size(), exp_addrs.size());
        for (int i = 0; i < exp_addrs.size() && i < got_addrs.size(); i++)
            chk({tag, ".line_addr"}, i, got_addrs[i], exp_addrs[i]);
        chk({tag, ".pix_count"}, 0, got_words.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < got_words.size(); i++)
            chk({tag, ".pix_data"}, i, got_words[i], exp_words[i]);
        chk({tag, ".line_done_count"}, 0, n_ldone, exp_ldone);
        chk({tag, ".frame_done_count"}, 0, n_fdone, exp_fdone);
        chk({tag, ".err_abort_count"}, 0, n_err, exp_err);
    endtask

    task automatic push_line(input logic [31:0] addr, input int kind, input logic [31:0] fill);
        push_bits(addr, AB);
        for (int w = 0; w < LB / W; w++) push_bits(kind == 0 ? fill : 32'($urandom), W);
        push_bits(32'($urandom), TRB);
    endtask

    initial begin
        lcd_sclk = 1'b0;
        lcd_si   = 1'b0;
        lcd_scs  = 1'b1;
        reset    = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(1);
        chk("reset.mode_valid", 0, 32'(mode_valid), 0);
        chk("reset.mode", 0, 32'(mode), 0);
        chk("reset.clear_all", 0, 32'(clear_all), 0);
        chk("reset.line_start", 0, 32'(line_start), 0);
        chk("reset.line_addr", 0, 32'(line_addr), 0);
        chk("reset.pix_valid", 0, 32'(pix_valid), 0);
        chk("reset.pix_data", 0, 32'(pix_data), 0);
        chk("reset.line_done", 0, 32'(line_done), 0);
        chk("reset.frame_done", 0, 32'(frame_done), 0);
        chk("reset.err_abort", 0, 32'(err_abort), 0);

        $display("[TB] frame while unarmed after reset, then same frame armed");
        frame_q.delete();
        push_bits(32'h01, MB);
        push_line(32'd5, 1, 32'h0);
        apply_stimulus(8, 1'b0);
        check_output("unarmed");
        apply_stimulus(8, 1'b1);
        check_output("rearmed");

        $display("[TB] single line of A5C3");
        frame_q.delete();
        push_bits(32'h01, MB);
        push_line(32'd5, 0, 32'hA5C3);
        apply_stimulus(8, 1'b1);
        check_output("a5c3");

        $display("[TB] two lines in one frame");
        frame_q.delete();
        push_bits(32'h01, MB);
        push_line(32'd0, 0, 32'hFFFF);
        push_line(32'd535, 0, 32'h0000);
        apply_stimulus(6, 1'b1);
        check_output("two_lines");

        $display("[TB] clear-all with dummy bits");
        frame_q.delete();
        push_bits(32'h04, MB);
        push_bits(32'($urandom), 10);
        apply_stimulus(8, 1'b1);
        check_output("clear_all");

        $display("[TB] abort after 100 data bits, then mode-only frame");
        frame_q.delete();
        push_bits(32'h01, MB);
        push_bits(32'd7, AB);
        for (int i = 0; i < 100; i++) frame_q.push_back(1'($urandom));
        apply_stimulus(8, 1'b1);
        check_output("abort");
        frame_q.delete();
        push_bits(32'h02, MB);
        apply_stimulus(8, 1'b1);
        check_output("mode_only");

        $display("[TB] three random lines at minimum link period");
        frame_q.delete();
        push_bits(32'($urandom) & 32'h3B, MB);
        for (int l = 0; l < 3; l++) push_line(32'($urandom_range(0, 1023)), 1, 32'h0);
        apply_stimulus(4, 1'b1);
        check_output("min_period");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
